br_enc_bin2onehot_accum: RTL and testbench

BR_ENC_BIN2ONEHOT_ACCUM -- requirements
Module: br_enc_bin2onehot_accum

---
 rtl/br_enc_bin2onehot_accum.sv | 127 ++++++++++++
 tb/tb_br_enc_bin2onehot_accum.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_enc_bin2onehot_accum.sv
`default_nettype none
// ============================================================================
// Module   : br_enc_bin2onehot_accum
// Brief    : Accumulates one-hot encodings of binary indices across a burst
//            and returns the multihot OR, a duplicate flag and a popcount.
// Revision : 1.0 - initial release
// ============================================================================
module br_enc_bin2onehot_accum #(
  parameter int NumValues                 = 2,
  parameter int BinWidth                  = (NumValues > 1) ? $clog2(NumValues) : 1,
  parameter int EnableInputRangeCheck     = 1,
  parameter int EnableAssertFinalNotValid = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             push_ready,
  input  logic                             push_valid,
  input  logic [BinWidth-1:0]              push_bin,
  input  logic                             push_last,
  input  logic                             pop_ready,
  output logic                             pop_valid,
  output logic [NumValues-1:0]             pop_multihot,
  output logic                             pop_dup,
  output logic [$clog2(NumValues+1)-1:0]   pop_count
);

  localparam int c_count_width = $clog2(NumValues + 1);

  if (NumValues < 1) begin : g_bad_num_values
    $error("NumValues must be at least 1");
  end
  if ((NumValues > 1) && (BinWidth < $clog2(NumValues))) begin : g_bad_bin_width
    $error("BinWidth too narrow for NumValues");
  end

  logic [NumValues-1:0]     r_acc;
  logic                     r_dup;
  logic                     r_pop_valid;
  logic [NumValues-1:0]     r_pop_multihot;
  logic                     r_pop_dup;

  logic [NumValues-1:0]     w_onehot;
  logic [NumValues-1:0]     w_acc_next;
  logic                     w_dup_next;
  logic                     w_push_ready;
  logic                     w_accept;
  logic                     w_pop_fire;
  logic [NumValues-1:0]     w_pop_multihot;
  logic [c_count_width-1:0] w_count;

  // Indices at or beyond NumValues match no bit, so they neither set a bit
  // nor raise the duplicate flag.
  for (genvar i = 0; i < NumValues; i++) begin : g_onehot
    assign w_onehot[i] = (push_bin == BinWidth'(i));
  end

  assign w_push_ready = !r_pop_valid || pop_ready;
  assign w_accept     = push_valid && w_push_ready;
  assign w_pop_fire   = r_pop_valid && pop_ready;
  assign w_acc_next   = r_acc | w_onehot;
  assign w_dup_next   = r_dup | (|(r_acc & w_onehot));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc          <= '0;
      r_dup          <= 1'b0;
      r_pop_valid    <= 1'b0;
      r_pop_multihot <= '0;
      r_pop_dup      <= 1'b0;
    end else begin
      if (w_pop_fire) begin
        r_pop_valid <= 1'b0;
      end
      // A last beat landing on the pop edge reloads the output with no bubble.
      if (w_accept) begin
        if (push_last) begin
          r_pop_multihot <= w_acc_next;
          r_pop_dup      <= w_dup_next;
          r_pop_valid    <= 1'b1;
          r_acc          <= '0;
          r_dup          <= 1'b0;
        end else begin
          r_acc <= w_acc_next;
          r_dup <= w_dup_next;
        end
      end
    end
  end

  assign w_pop_multihot = r_pop_valid ? r_pop_multihot : '0;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NumValues; i++) begin
      w_count = w_count + c_count_width'(w_pop_multihot[i]);
    end
  end

  assign push_ready   = w_push_ready;
  assign pop_valid    = r_pop_valid;
  assign pop_multihot = w_pop_multihot;
  assign pop_dup      = r_pop_valid ? r_pop_dup : 1'b0;
  assign pop_count    = w_count;

  if (EnableInputRangeCheck != 0) begin : g_range_chk
    localparam logic [BinWidth:0] c_num_values = (BinWidth + 1)'(NumValues);

    a_push_bin_in_range : assert property (
      @(posedge clk) disable iff (rst)
      push_valid |-> ({1'b0, push_bin} < c_num_values)
    );

    a_pop_count_nonzero : assert property (
      @(posedge clk) disable iff (rst)
      pop_valid |-> (pop_count != '0)
    );
  end

  final begin
    if (EnableAssertFinalNotValid != 0) begin
      a_final_push_idle : assert (!push_valid);
      a_final_pop_idle  : assert (!pop_valid);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_br_enc_bin2onehot_accum.sv
`default_nettype none
// Bench for br_enc_bin2onehot_accum (NumValues=5): directed bursts feed a
// scoreboard queue; a negedge monitor pops and compares every handshake.
module tb_br_enc_bin2onehot_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push_ready;
  logic       push_valid = 1'b0;
  logic [2:0] push_bin = '0;
  logic       push_last = 1'b0;
  logic       pop_ready = 1'b1;
  logic       pop_valid;
  logic [4:0] pop_multihot;
  logic       pop_dup;
  logic [2:0] pop_count;

  br_enc_bin2onehot_accum #(
    .NumValues(5),
    .BinWidth(3),
    .EnableInputRangeCheck(1),
    .EnableAssertFinalNotValid(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_ready(push_ready),
    .push_valid(push_valid),
    .push_bin(push_bin),
    .push_last(push_last),
    .pop_ready(pop_ready),
    .pop_valid(pop_valid),
    .pop_multihot(pop_multihot),
    .pop_dup(pop_dup),
    .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] mh;
    logic       dup;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   pop_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic expect_result(input logic [4:0] mh, input logic dup, input int cnt);
    exp_t e;
    e.mh = mh;
    e.dup = dup;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  // Stimulus changes at posedge+2; the pop_ready driver changes at posedge+1.
  task automatic send_beat(input int bin, input bit last, input bit chk_pv);
    int waited;
    waited = 0;
    push_valid = 1'b1;
    push_bin   = bin[2:0];
    push_last  = last;
    forever begin
      @(negedge clk);
      if (chk_pv && waited == 0) chk("b2b_pop_valid", int'(pop_valid), 1);
      if (push_ready) break;
      waited++;
      if (waited > 200) begin
        chk("push_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    push_valid = 1'b0;
    push_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (pop_mode)
        1:       pop_ready = 1'($urandom_range(0, 1));
        2:       pop_ready = 1'b0;
        default: pop_ready = 1'b1;
      endcase
    end
  end

  // Monitor: a handshake seen at the negedge completes on the following posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && pop_valid && pop_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_multihot", int'(pop_multihot), int'(e.mh));
          chk("pop_dup", int'(pop_dup), int'(e.dup));
          chk("pop_count", int'(pop_count), e.cnt);
        end
      end
    end
  end

  initial begin
    logic [4:0] mh;
    logic       dup;
    int         len;
    int         b;
    int         waited;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_pop_valid", int'(pop_valid), 0);
    chk("rst_push_ready", int'(push_ready), 1);
    chk("rst_pop_multihot", int'(pop_multihot), 0);
    chk("rst_pop_dup", int'(pop_dup), 0);
    chk("rst_pop_count", int'(pop_count), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);

    // 1,3,4(last) -> 11010, one-cycle latency
    expect_result(5'b11010, 1'b0, 3);
    send_beat(1, 1'b0, 1'b0);
    send_beat(3, 1'b0, 1'b0);
    send_beat(4, 1'b1, 1'b0);
    push_valid = 1'b0;
    @(negedge clk);
    chk("latency_pop_valid", int'(pop_valid), 1);
    @(posedge clk);
    #2;
    idle(2);

    // 2,2(last) -> duplicate
    expect_result(5'b00100, 1'b1, 1);
    send_beat(2, 1'b0, 1'b0);
    send_beat(2, 1'b1, 1'b0);
    idle(3);

    // Stall with pop_ready low for 4 cycles
    pop_mode = 2;
    idle(1);
    expect_result(5'b01000, 1'b0, 1);
    send_beat(3, 1'b1, 1'b0);
    push_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_push_ready", int'(push_ready), 0);
      chk("stall_pop_valid", int'(pop_valid), 1);
      chk("stall_pop_multihot", int'(pop_multihot), 5'b01000);
      chk("stall_pop_count", int'(pop_count), 1);
    end
    pop_mode = 0;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("unstall_push_ready", int'(push_ready), 1);
    @(posedge clk);
    #2;
    idle(2);

    // Back-to-back single-beat bursts
    for (int i = 0; i < 5; i++) begin
      mh = '0;
      mh[i] = 1'b1;
      expect_result(mh, 1'b0, 1);
      send_beat(i, 1'b1, i > 0);
    end
    push_valid = 1'b0;
    @(negedge clk);
    chk("b2b_pop_valid", int'(pop_valid), 1);
    @(posedge clk);
    #2;
    idle(3);

    // Reset mid-burst discards the partial accumulation
    send_beat(0, 1'b0, 1'b0);
    send_beat(1, 1'b0, 1'b0);
    push_valid = 1'b0;
    rst = 1'b1;
    #3;
    chk("midrst_pop_valid", int'(pop_valid), 0);
    chk("midrst_push_ready", int'(push_ready), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    expect_result(5'b10000, 1'b0, 1);
    send_beat(4, 1'b1, 1'b0);
    idle(3);

    // Random stalls against the model
    pop_mode = 1;
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 4);
      mh = '0;
      dup = 1'b0;
      for (int j = 0; j < len; j++) begin
        b = $urandom_range(0, 4);
        if (mh[b]) dup = 1'b1;
        mh[b] = 1'b1;
      end
      expect_result(mh, dup, $countones(mh));
    end
    // Replay the same bins: regenerate deterministically from stored results
    // is not possible, so bursts are driven from a parallel table instead.
    exp_q.delete();
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 4);
      mh = '0;
      dup = 1'b0;
      for (int j = 0; j < len; j++) begin
        b = $urandom_range(0, 4);
        if (j == len - 1) begin
          if (mh[b]) dup = 1'b1;
          mh[b] = 1'b1;
          expect_result(mh, dup, $countones(mh));
        end else begin
          if (mh[b]) dup = 1'b1;
          mh[b] = 1'b1;
        end
        send_beat(b, j == len - 1, 1'b0);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    push_valid = 1'b0;
    push_last  = 1'b0;
    pop_mode = 0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    #2;
    idle(3);
    chk("drain_remaining", exp_q.size(), 0);
    chk("final_pop_valid", int'(pop_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
